eqv_sweep_ctrl: RTL
===================

# eqv_sweep_ctrl

Exhaustive-sweep controller for the combinational equivalence test cases. It drives every input vector of a 12-input / 4-output gate-level circuit pair (golden and revised) and compares their outputs once per vector. It reports pass/fail, the first mismatching vector and its output difference. It sits between a host/testbench command interface and the two instantiated netlists, sequencing a shared input bus into both.

## Interface
Parameters:
- IN_W, 12, width of the shared input vector driven into both circuits
- OUT_W, 4, width of each circuit's output bus
- SETTLE, 0, extra hold cycles per vector before sampling (0..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled in IDLE or DONE
- abort  in  1  terminate a running sweep
- stop_on_fail  in  1  halt at first mismatch when 1; sampled at start
- vec_out  out  IN_W  registered vector applied to both circuits
- golden_in  in  OUT_W  golden circuit outputs (combinational from vec_out)
- revised_in  in  OUT_W  revised circuit outputs (combinational from vec_out)
- busy  out  1  high while in RUN
- done  out  1  high in DONE
- pass  out  1  valid with done; 1 = no mismatch found
- fail_vec  out  IN_W  first mismatching vector
- fail_diff  out  OUT_W  golden_in ^ revised_in at fail_vec
- vec_count  out  IN_W+1  number of vectors compared in the current or last sweep

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE, start=1: go to RUN. Clear vec_out, vec_count, fail_vec, fail_diff, pass and the hold counter. Latch stop_on_fail.
- RUN: hold vec_out for SETTLE+1 cycles. On the last hold cycle's edge:
  - sample golden_in/revised_in
  - increment vec_count
  - if they differ and no earlier mismatch occurred in this sweep, latch fail_vec=vec_out and fail_diff=XOR
- Then:
  - if mismatch and stop_on_fail latched: go to DONE, pass=0, vec_out frozen.
  - else if vec_out == all-ones: go to DONE, with pass=1 only if no mismatch occurred in the sweep.
  - else vec_out+1.
- RUN, abort=1: go to IDLE at that edge, discarding the sample. done=0, pass=0, results retained but invalid.
- abort takes priority over a same-edge sample or completion.
- start in RUN is ignored. abort in IDLE/DONE is ignored.
- DONE holds all outputs until start or rst.
- Reset mid-run: every output goes to 0 asynchronously. The FSM resumes in IDLE after rst deasserts.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, fail_vec=0, fail_diff=0, vec_count=0.
- start sampled at edge E0. From E0: busy=1, vec_out=0.
- The first compare occurs at edge E(SETTLE+1).
- Full sweep: busy for 2^IN_W·(SETTLE+1) cycles. done/pass are visible the cycle after the final compare edge.
- vec_out is driven only from a register; there is no combinational path from inputs to vec_out.
- Comparison result and counters are registered. Output latency from the sample edge is one cycle.

## Configuration
- MISMATCH_CNT_EN defined: adds output fail_cnt [15:0].
  - Counts every mismatching vector in the sweep, saturating at 0xFFFF.
  - Cleared at start and reset.
  - Most meaningful with stop_on_fail=0.
- MISMATCH_CNT_EN undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package eqv_sweep_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - default IN_W, OUT_W, SETTLE constants
  - the fail_cnt width constant
- One sub-module, sweep_pattern_gen, holds vec_out, the hold counter and the last-vector flag. Its inputs are clear and advance.
- The compare, result latching and FSM stay in eqv_sweep_ctrl.

## Test plan
- Both buses driven by the same function, stop_on_fail=0 → done after 4096 busy cycles, pass=1, vec_count=4096, fail_cnt=0.
- Revised differs from golden only at vector 0x5A3, bit 2, stop_on_fail=1 → done, pass=0, fail_vec=0x5A3, fail_diff=4'b0100, vec_count=0x5A4, vec_out frozen at 0x5A3.
- Mismatches at 0x5A3 and 0x7FF, stop_on_fail=0 → vec_count=4096, fail_vec=0x5A3, pass=0, fail_cnt=2.
- abort asserted 100 cycles into RUN → next cycle IDLE, busy=0, done=0. start pulsed during RUN is ignored.
- rst asserted mid-sweep → all outputs 0 without waiting for a clock edge. A later start produces a full clean sweep.
- SETTLE=2, identical circuits → busy for 12288 cycles. Each vec_out value is held exactly 3 cycles. pass=1.

Source files
------------

// File: rtl/eqv_sweep_pkg.sv
`default_nettype none
// ============================================================================
// eqv_sweep_pkg : shared types and defaults for the equivalence sweep block
// Revision 1.0 - initial release
// ============================================================================
package eqv_sweep_pkg;

  localparam int DEF_IN_W   = 12;
  localparam int DEF_OUT_W  = 4;
  localparam int DEF_SETTLE = 0;
  localparam int HOLD_W     = 4;
  localparam int FAIL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/sweep_pattern_gen.sv
`default_nettype none
// ============================================================================
// sweep_pattern_gen : walks the input vector 0..all-ones, holding each value
//                     for SETTLE+1 cycles while advance is high.
// Revision 1.0 - initial release
// ============================================================================
module sweep_pattern_gen
  import eqv_sweep_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic [IN_W-1:0] vec_out,
  output logic            sample,
  output logic            last_vec
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [IN_W-1:0]   VEC_ONE   = IN_W'(1);

  logic [IN_W-1:0]   vec_q;
  logic [IN_W-1:0]   vec_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  assign sample   = (hold_q == HOLD_LAST);
  assign last_vec = &vec_q;
  assign vec_out  = vec_q;

  // The final vector is never incremented, so a completed sweep rests on all-ones.
  always_comb begin
    vec_d  = vec_q;
    hold_d = hold_q;
    if (clear) begin
      vec_d  = '0;
      hold_d = '0;
    end else if (advance) begin
      if (sample) begin
        hold_d = '0;
        if (!last_vec) begin
          vec_d = vec_q + VEC_ONE;
        end
      end else begin
        hold_d = hold_q + HOLD_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q  <= '0;
      hold_q <= '0;
    end else begin
      vec_q  <= vec_d;
      hold_q <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eqv_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// eqv_sweep_ctrl : exhaustive golden-vs-revised sweep with first-fail capture.
//                  Define MISMATCH_CNT_EN to add the saturating fail_cnt output.
// Revision 1.0 - initial release
// ============================================================================
module eqv_sweep_ctrl
  import eqv_sweep_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stop_on_fail,
  output logic [IN_W-1:0]       vec_out,
  input  logic [OUT_W-1:0]      golden_in,
  input  logic [OUT_W-1:0]      revised_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IN_W-1:0]       fail_vec,
  output logic [OUT_W-1:0]      fail_diff,
`ifdef MISMATCH_CNT_EN
  output logic [FAIL_CNT_W-1:0] fail_cnt,
`endif
  output logic [IN_W:0]         vec_count
);

  localparam logic [IN_W:0] CNT_ONE = (IN_W+1)'(1);

  sweep_state_e     state_q;
  sweep_state_e     state_d;
  logic             stop_q;
  logic             stop_d;
  logic             seen_q;
  logic             seen_d;
  logic             pass_q;
  logic             pass_d;
  logic [IN_W-1:0]  fail_vec_q;
  logic [IN_W-1:0]  fail_vec_d;
  logic [OUT_W-1:0] fail_diff_q;
  logic [OUT_W-1:0] fail_diff_d;
  logic [IN_W:0]    count_q;
  logic [IN_W:0]    count_d;

  logic [OUT_W-1:0] diff;
  logic             mismatch;
  logic             launch;
  logic             advance;
  logic             sample;
  logic             last_vec;

  assign diff     = golden_in ^ revised_in;
  assign mismatch = |diff;
  assign launch   = start && (state_q != ST_RUN);
  // Stepping is withheld on abort and on a stopping mismatch so vec_out freezes.
  assign advance  = (state_q == ST_RUN) && !abort && !(sample && mismatch && stop_q);

  sweep_pattern_gen #(
    .IN_W   (IN_W),
    .SETTLE (SETTLE)
  ) u_pattern (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch),
    .advance  (advance),
    .vec_out  (vec_out),
    .sample   (sample),
    .last_vec (last_vec)
  );

`ifdef MISMATCH_CNT_EN
  logic [FAIL_CNT_W-1:0] fail_cnt_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_d;
  localparam logic [FAIL_CNT_W-1:0] FCNT_ONE = FAIL_CNT_W'(1);

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (launch) begin
      fail_cnt_d = '0;
    end else if ((state_q == ST_RUN) && !abort && sample && mismatch && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + FCNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt_q <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    stop_d      = stop_q;
    seen_d      = seen_q;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    fail_diff_d = fail_diff_q;
    count_d     = count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          stop_d      = stop_on_fail;
          seen_d      = 1'b0;
          pass_d      = 1'b0;
          fail_vec_d  = '0;
          fail_diff_d = '0;
          count_d     = '0;
        end
      end
      ST_RUN: begin
        // Abort wins over a coinciding sample; the sample is simply dropped.
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (sample) begin
          count_d = count_q + CNT_ONE;
          if (mismatch && !seen_q) begin
            seen_d      = 1'b1;
            fail_vec_d  = vec_out;
            fail_diff_d = diff;
          end
          if (mismatch && stop_q) begin
            state_d = ST_DONE;
            pass_d  = 1'b0;
          end else if (last_vec) begin
            state_d = ST_DONE;
            pass_d  = !(seen_q || mismatch);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stop_q      <= 1'b0;
      seen_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= '0;
      fail_diff_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      seen_q      <= seen_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      fail_diff_q <= fail_diff_d;
      count_q     <= count_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_vec  = fail_vec_q;
  assign fail_diff = fail_diff_q;
  assign vec_count = count_q;

endmodule
`default_nettype wire
